// File: rtl/sa_autosa_reset_sequencer_pkg.sv
// Shared types and sizing helpers for the AUTOSA partition reset sequencer.
package sa_autosa_rst_pkg;

    // Sequencer FSM states; encodings are visible on seq_state.
    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_RELEASE = 3'd1,
        ST_RUN     = 3'd2,
        ST_QUIESCE = 3'd3,
        ST_ASSERT  = 3'd4
    } seq_state_e;

    localparam int unsigned STATE_W = 3;

    // Counter width: enough bits for the largest terminal count plus one spare bit.
    function automatic int unsigned cnt_width(
        input int unsigned hold_cyc,
        input int unsigned release_gap,
        input int unsigned quiesce_timeout
    );
        int unsigned m;
        m = hold_cyc;
        if (release_gap > m) m = release_gap;
        if (quiesce_timeout > m) m = quiesce_timeout;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sa_autosa_reset_sequencer_if.sv
// Handshake and status bundle between the reset sequencer and its software/partition side.
interface sa_autosa_reset_sequencer_if #(
    parameter int unsigned NUM_PART = 4
);
    import sa_autosa_rst_pkg::*;

    logic                soft_rst_req;
    logic                soft_rst_ack;
    logic [NUM_PART-1:0] part_idle;
    logic [NUM_PART-1:0] part_rstn;
    logic                seq_busy;
    logic [STATE_W-1:0]  seq_state;
    logic                timeout_flag;
    logic                timeout_clr;

    // Software / partition side: issues requests, reports idleness.
    modport master (
        output soft_rst_req,
        output part_idle,
        output timeout_clr,
        input  soft_rst_ack,
        input  part_rstn,
        input  seq_busy,
        input  seq_state,
        input  timeout_flag
    );

    // Sequencer side.
    modport slave (
        input  soft_rst_req,
        input  part_idle,
        input  timeout_clr,
        output soft_rst_ack,
        output part_rstn,
        output seq_busy,
        output seq_state,
        output timeout_flag
    );

endinterface

// File: rtl/sa_autosa_reset_sequencer_gap_counter.sv
// Shared cycle counter: clears on request, otherwise counts; done flags the terminal count.
module sa_rst_gap_counter #(
    parameter int unsigned CW = 4
) (
    input  logic          autosa_clk,
    input  logic          autosa_rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic          done
);

    logic [CW-1:0] cnt;

    // Count enabled cycles; clr has priority so every state entry starts from zero.
    always_ff @(posedge autosa_clk or posedge autosa_rst) begin
        if (autosa_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == term);

endmodule

// File: rtl/sa_autosa_reset_sequencer.sv
// Staged partition reset release with software-requested quiesce/reset/re-release.
module sa_autosa_reset_sequencer
    import sa_autosa_rst_pkg::*;
#(
    parameter int unsigned NUM_PART        = 4,
    parameter int unsigned HOLD_CYC        = 8,
    parameter int unsigned RELEASE_GAP     = 4,
    parameter int unsigned QUIESCE_TIMEOUT = 32
) (
    input  logic                        autosa_clk,
    input  logic                        autosa_rst,
    sa_autosa_reset_sequencer_if.slave  bus
);

    localparam int unsigned CW   = cnt_width(HOLD_CYC, RELEASE_GAP, QUIESCE_TIMEOUT);
    localparam int unsigned IDXW = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PART - 1);

    seq_state_e          state_q;
    logic [IDXW-1:0]     idx_q;
    logic [NUM_PART-1:0] part_rstn_q;
    logic                ack_q;
    logic                busy_q;
    logic                soft_pending_q;
    logic                flag_q;

    logic                all_idle;
    logic                cnt_clr;
    logic [CW-1:0]       cnt_term;
    logic                cnt_done;
    logic                timeout_set;

    assign all_idle = &bus.part_idle;

    sa_rst_gap_counter #(
        .CW (CW)
    ) u_gap_counter (
        .autosa_clk (autosa_clk),
        .autosa_rst (autosa_rst),
        .clr        (cnt_clr),
        .en         (1'b1),
        .term       (cnt_term),
        .done       (cnt_done)
    );

    // Per-state terminal count and counter clear; counter is held at zero in RUN
    // and cleared on each exit so the next state always starts from zero.
    always_comb begin
        cnt_clr     = 1'b0;
        cnt_term    = '0;
        timeout_set = 1'b0;
        unique case (state_q)
            ST_HOLD, ST_ASSERT: begin
                cnt_term = CW'(HOLD_CYC - 1);
                cnt_clr  = cnt_done;
            end
            ST_RELEASE: begin
                cnt_term = CW'(RELEASE_GAP - 1);
                cnt_clr  = cnt_done;
            end
            ST_QUIESCE: begin
                cnt_term    = CW'(QUIESCE_TIMEOUT - 1);
                cnt_clr     = all_idle | cnt_done;
                timeout_set = cnt_done & ~all_idle;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Sequencer FSM with registered reset, ack and busy outputs.
    always_ff @(posedge autosa_clk or posedge autosa_rst) begin
        if (autosa_rst) begin
            state_q        <= ST_HOLD;
            idx_q          <= '0;
            part_rstn_q    <= '0;
            ack_q          <= 1'b0;
            busy_q         <= 1'b1;
            soft_pending_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_done) state_q <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (cnt_done) begin
                        part_rstn_q[idx_q] <= 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_RUN;
                            idx_q   <= '0;
                            busy_q  <= 1'b0;
                            if (soft_pending_q) begin
                                ack_q          <= 1'b1;
                                soft_pending_q <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (ack_q && !bus.soft_rst_req) begin
                        ack_q <= 1'b0;
                    end else if (bus.soft_rst_req && !ack_q && !soft_pending_q) begin
                        state_q <= ST_QUIESCE;
                        busy_q  <= 1'b1;
                    end
                end
                ST_QUIESCE: begin
                    if (all_idle || cnt_done) begin
                        state_q     <= ST_ASSERT;
                        part_rstn_q <= '0;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_done) begin
                        state_q        <= ST_RELEASE;
                        soft_pending_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    // Sticky quiesce-timeout flag; a set beats a simultaneous clear.
    always_ff @(posedge autosa_clk or posedge autosa_rst) begin
        if (autosa_rst) begin
            flag_q <= 1'b0;
        end else if (timeout_set) begin
            flag_q <= 1'b1;
        end else if (bus.timeout_clr) begin
            flag_q <= 1'b0;
        end
    end

    assign bus.part_rstn    = part_rstn_q;
    assign bus.soft_rst_ack = ack_q;
    assign bus.seq_busy     = busy_q;
    assign bus.seq_state    = state_q;
    assign bus.timeout_flag = flag_q;

endmodule

// File: tb/tb_sa_autosa_reset_sequencer.sv
// Directed bench for the partition reset sequencer with hand-computed edge timings.
module tb_sa_autosa_reset_sequencer;

    logic autosa_clk;
    logic autosa_rst;
    int unsigned edge_cnt;
    int unsigned n_vec;
    int unsigned n_err;

    sa_autosa_reset_sequencer_if #(.NUM_PART(4)) bus ();

    sa_autosa_reset_sequencer #(
        .NUM_PART        (4),
        .HOLD_CYC        (8),
        .RELEASE_GAP     (4),
        .QUIESCE_TIMEOUT (32)
    ) dut (
        .autosa_clk (autosa_clk),
        .autosa_rst (autosa_rst),
        .bus        (bus.slave)
    );

    initial autosa_clk = 1'b0;
    always #5 autosa_clk = ~autosa_clk;

    // Edge index since reset release: the first rising edge after release is edge 1.
    always @(posedge autosa_clk or posedge autosa_rst) begin
        if (autosa_rst) edge_cnt <= 0;
        else            edge_cnt <= edge_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_cnt, got, exp);
        end
    endtask

    // Advance to the falling edge following rising edge n.
    task automatic at_edge(input int unsigned n);
        while (edge_cnt < n) @(negedge autosa_clk);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] rstn, input logic [2:0] st,
                              input logic busy, input logic ack, input logic flag);
        check_val({tag, ".rstn"}, 32'(bus.part_rstn), 32'(rstn));
        check_val({tag, ".state"}, 32'(bus.seq_state), 32'(st));
        check_val({tag, ".busy"}, 32'(bus.seq_busy), 32'(busy));
        check_val({tag, ".ack"}, 32'(bus.soft_rst_ack), 32'(ack));
        check_val({tag, ".flag"}, 32'(bus.timeout_flag), 32'(flag));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        autosa_rst = 1'b1;
        bus.soft_rst_req = 1'b0;
        bus.part_idle = 4'b1111;
        bus.timeout_clr = 1'b0;
        repeat (3) @(negedge autosa_clk);
        check_outs("rst", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);
        autosa_rst = 1'b0;

        // Power-on staged release.
        at_edge(7);  check_outs("po7", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);
        at_edge(8);  check_outs("po8", 4'b0000, 3'd1, 1'b1, 1'b0, 1'b0);
        at_edge(11); check_val("po11.rstn", 32'(bus.part_rstn), 32'h0);
        at_edge(12); check_val("po12.rstn", 32'(bus.part_rstn), 32'h1);
        at_edge(15); check_val("po15.rstn", 32'(bus.part_rstn), 32'h1);
        at_edge(16); check_val("po16.rstn", 32'(bus.part_rstn), 32'h3);
        at_edge(20); check_val("po20.rstn", 32'(bus.part_rstn), 32'h7);
        at_edge(23); check_outs("po23", 4'b0111, 3'd1, 1'b1, 1'b0, 1'b0);
        at_edge(24); check_outs("po24", 4'b1111, 3'd2, 1'b0, 1'b0, 1'b0);

        // Soft reset, all partitions idle.
        at_edge(40); bus.soft_rst_req = 1'b1;
        at_edge(41); check_outs("sr41", 4'b1111, 3'd3, 1'b1, 1'b0, 1'b0);
        at_edge(42); check_outs("sr42", 4'b0000, 3'd4, 1'b1, 1'b0, 1'b0);
        at_edge(53); check_val("sr53.rstn", 32'(bus.part_rstn), 32'h0);
        at_edge(54); check_val("sr54.rstn", 32'(bus.part_rstn), 32'h1);
        at_edge(58); check_val("sr58.rstn", 32'(bus.part_rstn), 32'h3);
        at_edge(62); check_val("sr62.rstn", 32'(bus.part_rstn), 32'h7);
        at_edge(65); check_outs("sr65", 4'b0111, 3'd1, 1'b1, 1'b0, 1'b0);
        at_edge(66); check_outs("sr66", 4'b1111, 3'd2, 1'b0, 1'b1, 1'b0);
        at_edge(69); check_outs("sr69", 4'b1111, 3'd2, 1'b0, 1'b1, 1'b0);
        at_edge(70); bus.soft_rst_req = 1'b0;
        at_edge(71); check_outs("sr71", 4'b1111, 3'd2, 1'b0, 1'b0, 1'b0);

        // Quiesce timeout; clear held during the setting edge must lose.
        at_edge(80); bus.soft_rst_req = 1'b1; bus.part_idle = 4'b0111;
        at_edge(81);  check_outs("to81", 4'b1111, 3'd3, 1'b1, 1'b0, 1'b0);
        at_edge(112); check_outs("to112", 4'b1111, 3'd3, 1'b1, 1'b0, 1'b0);
        bus.timeout_clr = 1'b1;
        at_edge(113); check_outs("to113", 4'b0000, 3'd4, 1'b1, 1'b0, 1'b1);
        bus.timeout_clr = 1'b0;
        at_edge(121); check_outs("to121", 4'b0000, 3'd1, 1'b1, 1'b0, 1'b1);
        at_edge(125); check_val("to125.rstn", 32'(bus.part_rstn), 32'h1);
        at_edge(137); check_outs("to137", 4'b1111, 3'd2, 1'b0, 1'b1, 1'b1);
        bus.soft_rst_req = 1'b0;
        at_edge(138); check_outs("to138", 4'b1111, 3'd2, 1'b0, 1'b0, 1'b1);
        at_edge(140); bus.timeout_clr = 1'b1;
        at_edge(141); check_val("to141.flag", 32'(bus.timeout_flag), 32'h0);
        bus.timeout_clr = 1'b0;

        // Idle arrives on the exact timeout cycle: no flag.
        at_edge(150); bus.soft_rst_req = 1'b1; bus.part_idle = 4'b0111;
        at_edge(151); check_val("ie151.state", 32'(bus.seq_state), 32'd3);
        at_edge(182); bus.part_idle = 4'b1111;
        at_edge(183); check_outs("ie183", 4'b0000, 3'd4, 1'b1, 1'b0, 1'b0);
        at_edge(207); check_outs("ie207", 4'b1111, 3'd2, 1'b0, 1'b1, 1'b0);
        bus.soft_rst_req = 1'b0;
        at_edge(208); check_val("ie208.ack", 32'(bus.soft_rst_ack), 32'h0);

        // Async reset mid-release, then power-on with request already held.
        autosa_rst = 1'b1;
        @(negedge autosa_clk);
        autosa_rst = 1'b0;
        at_edge(16); check_outs("ar16", 4'b0011, 3'd1, 1'b1, 1'b0, 1'b0);
        at_edge(17); #1 autosa_rst = 1'b1;
        #1 check_outs("ar17", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0);
        bus.soft_rst_req = 1'b1;
        repeat (2) @(negedge autosa_clk);
        autosa_rst = 1'b0;
        at_edge(12); check_val("rq12.rstn", 32'(bus.part_rstn), 32'h1);
        at_edge(24); check_outs("rq24", 4'b1111, 3'd2, 1'b0, 1'b0, 1'b0);
        at_edge(25); check_outs("rq25", 4'b1111, 3'd3, 1'b1, 1'b0, 1'b0);
        at_edge(26); check_outs("rq26", 4'b0000, 3'd4, 1'b1, 1'b0, 1'b0);
        at_edge(50); check_outs("rq50", 4'b1111, 3'd2, 1'b0, 1'b1, 1'b0);
        at_edge(60); check_outs("rq60", 4'b1111, 3'd2, 1'b0, 1'b1, 1'b0);
        bus.soft_rst_req = 1'b0;
        at_edge(61); check_outs("rq61", 4'b1111, 3'd2, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
